// File: rtl/proj2aff_conv.sv
// Projective (Lopez-Dahab) to affine conversion over GF(2^233): x = X/Z, y = Y/Z^2.
// Define PROJ2AFF_TIMEOUT_EN to enable the WAIT_INV watchdog and ERROR strobe.
module proj2aff_conv #(
  parameter int           N       = 233,
  parameter logic [N-1:0] POLY    = (N'(1) << 74) | N'(1),
  parameter int           TIMEOUT = 4095
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         IN_VALID,
  input  logic [N-1:0] X_IN,
  input  logic [N-1:0] Y_IN,
  input  logic [N-1:0] Z_IN,
  output logic         BUSY,
  output logic         INV_IN_VALID,
  output logic [N-1:0] INV_DIN,
  input  logic [N-1:0] INV_DOUT,
  input  logic         INV_OUT_VALID,
  output logic [N-1:0] XA,
  output logic [N-1:0] YA,
  output logic         INF,
  output logic         OUT_VALID,
  output logic         ERROR
);

  // Handshake: IN_VALID is a strobe taken only in IDLE (BUSY=0, not DONE); INV_IN_VALID,
  // INV_OUT_VALID, OUT_VALID and ERROR are single-cycle pulses with no back-pressure.
  typedef enum logic [2:0] {IDLE, LOAD_INV, WAIT_INV, MUL_X, MUL_Y, DONE} state_t;

  localparam int            CW      = $clog2(N);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [N-1:0]  zinv_q, zinv_d, zinv2_q, zinv2_d;
  logic [N-1:0]  acc_q, acc_d, acc_step;
  logic [N-1:0]  xa_q, xa_d, ya_q, ya_d;
  logic          inf_q, inf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mul_bit;
  logic          tmo_hit;

  function automatic logic [N-1:0] gf_xtime(input logic [N-1:0] a);
    gf_xtime = {a[N-2:0], 1'b0} ^ (a[N-1] ? POLY : '0);
  endfunction

  // Squaring spreads bits to even positions; fold x^i (i >= N) back as x^(i-N)*POLY.
  function automatic logic [N-1:0] gf_sqr(input logic [N-1:0] a);
    logic [2*N-2:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[2*i] = a[i];
    for (int i = 2*N-2; i >= N; i--) begin
      if (w[i]) begin
        w[i] = 1'b0;
        w    = w ^ ({{(N-1){1'b0}}, POLY} << (i - N));
      end
    end
    return w[N-1:0];
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin : p_state
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    case (state_q)
      IDLE:     if (IN_VALID) state_d = (Z_IN == '0) ? DONE : LOAD_INV;
      LOAD_INV: state_d = WAIT_INV;
      WAIT_INV: begin
        if (INV_OUT_VALID) state_d = MUL_X;
        else if (tmo_hit)  state_d = IDLE;
      end
      MUL_X:    if (cnt_q == '0) state_d = MUL_Y;
      MUL_Y:    if (cnt_q == '0) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin : p_out
    BUSY         = 1'b0;
    INV_IN_VALID = 1'b0;
    OUT_VALID    = 1'b0;
    case (state_q)
      LOAD_INV: begin
        BUSY         = 1'b1;
        INV_IN_VALID = 1'b1;
      end
      WAIT_INV, MUL_X, MUL_Y: BUSY = 1'b1;
      DONE:     OUT_VALID = 1'b1;
      default:  ;
    endcase
  end

  // MSB-first shift-and-add step shared by both multiplications.
  assign mul_bit  = (state_q == MUL_X) ? x_q[cnt_q] : y_q[cnt_q];
  assign acc_step = gf_xtime(acc_q) ^
                    (mul_bit ? ((state_q == MUL_X) ? zinv_q : zinv2_q) : '0);

  always_comb begin : p_datapath
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zinv_d  = zinv_q;
    zinv2_d = zinv2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    inf_d   = inf_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          x_d = X_IN;
          y_d = Y_IN;
          z_d = Z_IN;
          if (Z_IN == '0) begin
            inf_d = 1'b1;
            xa_d  = '0;
            ya_d  = '0;
          end else begin
            inf_d = 1'b0;
          end
        end
      end
      WAIT_INV: begin
        if (INV_OUT_VALID) begin
          zinv_d  = INV_DOUT;
          zinv2_d = gf_sqr(INV_DOUT);
          acc_d   = '0;
          cnt_d   = CNT_TOP;
        end
      end
      MUL_X, MUL_Y: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          acc_d = '0;
          cnt_d = CNT_TOP;
          if (state_q == MUL_X) xa_d = acc_step;
          else                  ya_d = acc_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin : p_regs
    if (!RST_N) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zinv_q  <= '0;
      zinv2_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      inf_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zinv_q  <= zinv_d;
      zinv2_q <= zinv2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      inf_q   <= inf_d;
    end
  end

`ifdef PROJ2AFF_TIMEOUT_EN
  logic [11:0] tmo_q, tmo_d;
  logic        err_q;

  // Counter is 0 on the first WAIT_INV cycle; expiry after TIMEOUT silent cycles.
  assign tmo_d   = (state_q == WAIT_INV) ? tmo_q + 12'd1 : '0;
  assign tmo_hit = (state_q == WAIT_INV) && !INV_OUT_VALID && (tmo_q == 12'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin : p_tmo
    if (!RST_N) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= tmo_hit;
    end
  end

  assign ERROR = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
  assign ERROR          = 1'b0;
`endif

  assign INV_DIN = z_q;
  assign XA      = xa_q;
  assign YA      = ya_q;
  assign INF     = inf_q;

endmodule

// File: tb/tb_proj2aff_conv.sv
// Directed bench for proj2aff_conv: vector table with an inverter stub, plus
// hand-written sequences for busy/done/reset/timeout corner cases.
module tb_proj2aff_conv;
  localparam int N   = 233;
  localparam int LAT = 2*N + 1;
  localparam logic [N-1:0] TB_POLY = (233'd1 << 74) | 233'd1;
`ifdef PROJ2AFF_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 4095;
`endif

  logic         CLK, RST_N, IN_VALID, INV_OUT_VALID;
  logic [N-1:0] X_IN, Y_IN, Z_IN, INV_DOUT;
  logic         BUSY, INV_IN_VALID, INF, OUT_VALID, ERROR;
  logic [N-1:0] INV_DIN, XA, YA;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0] x, y, z, zinv, xa, ya;
    logic         inf;
  } vec_t;

  vec_t vecs[6];

  proj2aff_conv #(.N(N), .TIMEOUT(TB_TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID),
    .X_IN(X_IN), .Y_IN(Y_IN), .Z_IN(Z_IN),
    .BUSY(BUSY), .INV_IN_VALID(INV_IN_VALID), .INV_DIN(INV_DIN),
    .INV_DOUT(INV_DOUT), .INV_OUT_VALID(INV_OUT_VALID),
    .XA(XA), .YA(YA), .INF(INF), .OUT_VALID(OUT_VALID), .ERROR(ERROR)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Reference field arithmetic (LSB-first multiply, Fermat-style inverse)
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) r = r ^ t;
      t = t[N-1] ? ({t[N-2:0], 1'b0} ^ TB_POLY) : {t[N-2:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] gf_inv(input logic [N-1:0] a);
    logic [N-1:0] r, t;
    r = 233'd1;
    t = a;
    for (int i = 1; i < N; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  task automatic check_val(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: one request, inverter stub answers 10 cycles after its start pulse.
  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    IN_VALID = 1'b1;
    X_IN = v.x;
    Y_IN = v.y;
    Z_IN = v.z;
    @(negedge CLK);
    IN_VALID = 1'b0;
    if (v.z == '0) begin
      check_bit({tag, " out_valid"}, OUT_VALID, 1'b1);
      check_bit({tag, " inv_start"}, INV_IN_VALID, 1'b0);
      check_bit({tag, " busy_done"}, BUSY, 1'b0);
    end else begin
      check_bit({tag, " busy"}, BUSY, 1'b1);
      check_bit({tag, " inv_start"}, INV_IN_VALID, 1'b1);
      check_val({tag, " inv_din"}, INV_DIN, v.z);
      @(negedge CLK);
      check_bit({tag, " inv_pulse"}, INV_IN_VALID, 1'b0);
      repeat (9) @(negedge CLK);
      INV_OUT_VALID = 1'b1;
      INV_DOUT = v.zinv;
      @(negedge CLK);
      INV_OUT_VALID = 1'b0;
      INV_DOUT = '0;
      lat = 1;
      while (!OUT_VALID && lat < LAT + 20) begin
        @(negedge CLK);
        lat++;
      end
      check_int({tag, " latency"}, lat, LAT);
      check_bit({tag, " busy_done"}, BUSY, 1'b0);
    end
    check_val({tag, " xa"}, XA, v.xa);
    check_val({tag, " ya"}, YA, v.ya);
    check_bit({tag, " inf"}, INF, v.inf);
    @(negedge CLK);
    check_bit({tag, " out_pulse"}, OUT_VALID, 1'b0);
  endtask

  initial begin
    vec_t  cv;
    int    lat;
    bit    busy_ok;
    logic [N-1:0] zc, zci;

    vecs[0] = '{x: 233'h1234, y: 233'hABCD, z: 233'd1, zinv: 233'd1,
                xa: 233'h1234, ya: 233'hABCD, inf: 1'b0};
    vecs[1] = '{x: 233'd2, y: 233'd4, z: 233'd2, zinv: (233'd1 << 232) | (233'd1 << 73),
                xa: 233'd1, ya: 233'd1, inf: 1'b0};
    vecs[2] = '{x: 233'hDEAD, y: 233'hBEEF, z: 233'd0, zinv: 233'd0,
                xa: 233'd0, ya: 233'd0, inf: 1'b1};
    vecs[3] = '{x: 233'd1, y: 233'd1, z: 233'd2, zinv: (233'd1 << 232) | (233'd1 << 73),
                xa: (233'd1 << 232) | (233'd1 << 73), ya: (233'd1 << 231) | (233'd1 << 72),
                inf: 1'b0};
    vecs[4] = '{x: '1, y: 233'd1 << 232, z: 233'd1, zinv: 233'd1,
                xa: '1, ya: 233'd1 << 232, inf: 1'b0};
    vecs[5] = '{x: 233'd1, y: 233'd1, z: (233'd1 << 232) | (233'd1 << 73), zinv: 233'd2,
                xa: 233'd2, ya: 233'd4, inf: 1'b0};

    // Reset
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    INV_OUT_VALID = 1'b0;
    X_IN = '0;
    Y_IN = '0;
    Z_IN = '0;
    INV_DOUT = '0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_bit("rst busy", BUSY, 1'b0);
    check_bit("rst inv_start", INV_IN_VALID, 1'b0);
    check_bit("rst out_valid", OUT_VALID, 1'b0);
    check_bit("rst inf", INF, 1'b0);
    check_bit("rst error", ERROR, 1'b0);
    check_val("rst xa", XA, '0);
    check_val("rst ya", YA, '0);
    check_val("rst inv_din", INV_DIN, '0);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Inverter strobe while idle must be ignored
    INV_OUT_VALID = 1'b1;
    INV_DOUT = 233'h55;
    @(negedge CLK);
    INV_OUT_VALID = 1'b0;
    check_bit("idle inv busy", BUSY, 1'b0);
    repeat (3) @(negedge CLK);
    check_bit("idle inv out_valid", OUT_VALID, 1'b0);

    // Second request during MUL_X is ignored; BUSY held
    IN_VALID = 1'b1;
    X_IN = 233'h5555;
    Y_IN = 233'h0F0F;
    Z_IN = 233'd1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    INV_OUT_VALID = 1'b1;
    INV_DOUT = 233'd1;
    @(negedge CLK);
    INV_OUT_VALID = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!OUT_VALID && lat < LAT + 20) begin
      if (!BUSY) busy_ok = 1'b0;
      IN_VALID = (lat == 50);
      if (lat == 50) begin
        X_IN = 233'h9999;
        Y_IN = 233'h8888;
        Z_IN = '0;
      end
      @(negedge CLK);
      lat++;
    end
    IN_VALID = 1'b0;
    check_bit("busy held", busy_ok, 1'b1);
    check_int("busy latency", lat, LAT);
    check_val("busy xa", XA, 233'h5555);
    check_val("busy ya", YA, 233'h0F0F);
    check_bit("busy inf", INF, 1'b0);
    check_val("busy z kept", INV_DIN, 233'd1);
    @(negedge CLK);

    // IN_VALID during DONE ignored, accepted the following cycle
    IN_VALID = 1'b1;
    X_IN = 233'h77;
    Y_IN = 233'h66;
    Z_IN = '0;
    @(negedge CLK);
    check_bit("done1 out_valid", OUT_VALID, 1'b1);
    @(negedge CLK);
    check_bit("done ignore", OUT_VALID, 1'b0);
    @(negedge CLK);
    check_bit("done reaccept", OUT_VALID, 1'b1);
    IN_VALID = 1'b0;
    @(negedge CLK);

    // Reset in the middle of MUL_Y
    IN_VALID = 1'b1;
    X_IN = 233'h1234;
    Y_IN = 233'hABCD;
    Z_IN = 233'd1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    INV_OUT_VALID = 1'b1;
    INV_DOUT = 233'd1;
    @(negedge CLK);
    INV_OUT_VALID = 1'b0;
    repeat (N + 30) @(negedge CLK);
    check_bit("muly busy", BUSY, 1'b1);
    check_val("muly xa", XA, 233'h1234);
    RST_N = 1'b0;
    #1;
    check_bit("mrst busy", BUSY, 1'b0);
    check_bit("mrst out_valid", OUT_VALID, 1'b0);
    check_val("mrst xa", XA, '0);
    check_val("mrst ya", YA, '0);
    check_val("mrst inv_din", INV_DIN, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Fresh request against a software inverter
    zc  = 233'h1_2345_6789_ABCD_EF01_0203_0405_0607_0809_0A0B_0C0D_0E0F_1011_1213;
    zci = gf_inv(zc);
    cv.x = 233'h0_DEAD_BEEF_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA;
    cv.y = 233'h1_0F0F_F0F0_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_0000_0001_0002;
    cv.z = zc;
    cv.zinv = zci;
    cv.xa = gf_mul(cv.x, zci);
    cv.ya = gf_mul(cv.y, gf_mul(zci, zci));
    cv.inf = 1'b0;
    run_txn(cv, "chain");
    check_val("chain x*Z", gf_mul(XA, zc), cv.x);
    check_val("chain y*Z2", gf_mul(YA, gf_mul(zc, zc)), cv.y);

`ifdef PROJ2AFF_TIMEOUT_EN
    // Inverter never answers
    IN_VALID = 1'b1;
    X_IN = 233'h3;
    Y_IN = 233'h4;
    Z_IN = 233'd5;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check_bit("tmo inv_start", INV_IN_VALID, 1'b1);
    lat = 0;
    busy_ok = 1'b1;
    while (!ERROR && lat < 3 * TB_TIMEOUT) begin
      @(negedge CLK);
      lat++;
      if (OUT_VALID) busy_ok = 1'b0;
    end
    check_int("tmo error delay", lat, TB_TIMEOUT + 1);
    check_bit("tmo no out_valid", busy_ok, 1'b1);
    check_bit("tmo busy", BUSY, 1'b0);
    check_val("tmo xa kept", XA, cv.xa);
    check_bit("tmo inf kept", INF, 1'b0);
    @(negedge CLK);
    check_bit("tmo error pulse", ERROR, 1'b0);
`else
    check_bit("error tied", ERROR, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
